vga_pattern_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator; the next generation of the fixed 640x480, 3-bit-colour VGA block. Programmable porch/sync timing, pixel-clock divider, sync polarity and per-channel colour depth are added, plus four selectable patterns. Mode and colour are latched once per frame so they never tear. It drives the board VGA connector directly and exports pixel coordinates for downstream overlay logic.

---
 rtl/vga_pattern_gen_if.sv | 31 +++
 rtl/vga_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle of the VGA pattern generator.
// The generator uses the master side: pattern controls go in, connector signals and coordinates come out.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4,
    parameter int CNT_W   = 10
);
    logic [1:0]         mode;
    logic [2:0]         sw;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic [CNT_W-1:0]   pixel_x;
    logic [CNT_W-1:0]   pixel_y;
    logic               pixel_tick;
    logic               frame_start;

    modport master (
        input  mode, sw,
        output red, green, blue, hsync, vsync, video_on,
               pixel_x, pixel_y, pixel_tick, frame_start
    );

    modport slave (
        output mode, sw,
        input  red, green, blue, hsync, vsync, video_on,
               pixel_x, pixel_y, pixel_tick, frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator with programmable porches, pixel divider and sync polarity.
// Pattern mode and colour are sampled only while the raster sits on pixel (0,0), so a frame never tears.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter bit SYNC_POL = 1'b0,
    parameter int COLOR_W  = 4,
    parameter int CNT_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    vga_pattern_gen_if.master vga
);
    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_MOVING  = 2'd3
    } pattern_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] FC_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W:0]   BAR_SPAN = (CNT_W + 1)'(15);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic [CNT_W-1:0] fc;
    logic [CNT_W-1:0] bar_pos;
    logic [2:0]       bar_idx;
    logic             armed;
    logic             wrap_pend;
    pattern_t         mode_q;
    logic [2:0]       sw_q;

    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap;
    logic             latch_en;
    logic             active;
    logic             hs_i;
    logic             vs_i;
    logic             in_bar;
    pattern_t         mode_eff;
    logic [2:0]       sw_eff;
    logic [2:0]       code;

    assign h_wrap     = (h == H_LAST);
    assign v_wrap     = (v == V_LAST);
    assign frame_wrap = h_wrap && v_wrap;
    assign active     = (h < H_ACT) && (v < V_ACT);
    assign hs_i       = (h >= HS_START) && (h < HS_END);
    assign vs_i       = (v >= VS_START) && (v < VS_END);
    assign in_bar     = (h >= fc) && ({1'b0, h} <= ({1'b0, fc} + BAR_SPAN));

    // Nothing latches until the first frame wrap, so the frame right after reset uses the reset mode/colour.
    assign latch_en = armed && (h == '0) && (v == '0);
    assign mode_eff = latch_en ? pattern_t'(vga.mode) : mode_q;
    assign sw_eff   = latch_en ? vga.sw : sw_q;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        code = 3'b000;
        unique case (mode_eff)
            PAT_SOLID:   code = sw_eff;
            PAT_BARS:    code = 3'd7 - bar_idx;
            PAT_CHECKER: code = (h[5] ^ v[5]) ? ~sw_eff : sw_eff;
            PAT_MOVING:  code = in_bar ? sw_eff : 3'b000;
            default:     code = 3'b000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (div == DIV_LAST);
            div  <= (div == DIV_LAST) ? '0 : div + DIV_ONE;
        end
    end

    // Raster counters plus a bar tracker that follows h/BAR_W without a divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h         <= '0;
            v         <= '0;
            fc        <= '0;
            bar_pos   <= '0;
            bar_idx   <= '0;
            armed     <= 1'b0;
            wrap_pend <= 1'b0;
            mode_q    <= PAT_SOLID;
            sw_q      <= '0;
        end else begin
            if (tick) begin
                if (h_wrap) begin
                    h       <= '0;
                    bar_pos <= '0;
                    bar_idx <= '0;
                    v       <= v_wrap ? '0 : v + CNT_ONE;
                    if (v_wrap) begin
                        fc <= (fc == FC_LAST) ? '0 : fc + CNT_ONE;
                    end
                end else begin
                    h <= h + CNT_ONE;
                    if (bar_pos == BAR_LAST) begin
                        bar_pos <= '0;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_pos <= bar_pos + CNT_ONE;
                    end
                end
            end
            wrap_pend <= tick && frame_wrap;
            if (tick && frame_wrap) begin
                armed <= 1'b1;
            end
            if (latch_en) begin
                mode_q <= mode_eff;
                sw_q   <= sw_eff;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga.pixel_x     <= '0;
            vga.pixel_y     <= '0;
            vga.video_on    <= 1'b0;
            vga.hsync       <= ~SYNC_POL;
            vga.vsync       <= ~SYNC_POL;
            vga.red         <= '0;
            vga.green       <= '0;
            vga.blue        <= '0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.pixel_x     <= h;
            vga.pixel_y     <= v;
            vga.video_on    <= active;
            vga.hsync       <= SYNC_POL ? hs_i : ~hs_i;
            vga.vsync       <= SYNC_POL ? vs_i : ~vs_i;
            vga.red         <= active ? {COLOR_W{code[2]}} : '0;
            vga.green       <= active ? {COLOR_W{code[1]}} : '0;
            vga.blue        <= active ? {COLOR_W{code[0]}} : '0;
            vga.frame_start <= wrap_pend;
        end
    end

    assign vga.pixel_tick = tick;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: instance a keeps default timing with a short frame,
// instance b runs one clock per pixel with active-high syncs for patterns and async reset.
module tb_vga_pattern_gen;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    int n_checks = 0;
    int n_pass   = 0;
    int b_ticks  = 0;

    int hs_first, hs_last, von_fall, prev_x, prev_y, y_before, y_after;
    int vs_min, vs_max, vs_clocks, fs1, fs2;
    bit prev_von, wrapped, seen;

    vga_pattern_gen_if #(.COLOR_W(4), .CNT_W(10)) a_if ();
    vga_pattern_gen_if #(.COLOR_W(4), .CNT_W(10)) b_if ();

    vga_pattern_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_a (
        .clk  (clk),
        .reset(rst_a),
        .vga  (a_if.master)
    );

    vga_pattern_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk  (clk),
        .reset(rst_b),
        .vga  (b_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (b_if.pixel_tick) b_ticks++;
    endtask

    function automatic logic [31:0] rgb_a();
        return {20'd0, a_if.red, a_if.green, a_if.blue};
    endfunction

    function automatic logic [31:0] rgb_b();
        return {20'd0, b_if.red, b_if.green, b_if.blue};
    endfunction

    task automatic wait_b(input int x, input int y, input string tag);
        int n = 0;
        while (!(b_if.pixel_x == x && b_if.pixel_y == y) && n < 7000) begin
            step();
            n++;
        end
        check({tag, "_reach"}, 32'(b_if.pixel_x == x && b_if.pixel_y == y), 1);
    endtask

    task automatic wait_fs_b(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!b_if.frame_start && n < 7000);
        check({tag, "_seen"}, 32'(b_if.frame_start), 1);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.mode = 2'd0;
        a_if.sw   = 3'b000;
        b_if.mode = 2'd0;
        b_if.sw   = 3'b000;

        // Reset values held over three clocks
        repeat (3) step();
        check("a_rst_x", a_if.pixel_x, 0);
        check("a_rst_y", a_if.pixel_y, 0);
        check("a_rst_tick", a_if.pixel_tick, 0);
        check("a_rst_fs", a_if.frame_start, 0);
        check("a_rst_von", a_if.video_on, 0);
        check("a_rst_rgb", rgb_a(), 0);
        check("a_rst_hsync", a_if.hsync, 1);
        check("a_rst_vsync", a_if.vsync, 1);
        check("b_rst_hsync", b_if.hsync, 0);
        check("b_rst_vsync", b_if.vsync, 0);

        // Divider: tick on every 4th clock, pixel_x steps every 4 clocks
        rst_a = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            check("a_tick", a_if.pixel_tick, 32'(e % 4 == 0));
            if (e == 1) begin
                check("a_x_e1", a_if.pixel_x, 0);
                check("a_y_e1", a_if.pixel_y, 0);
                check("a_von_e1", a_if.video_on, 1);
            end
            if (e == 6)  check("a_x_e6", a_if.pixel_x, 1);
            if (e == 10) check("a_x_e10", a_if.pixel_x, 2);
        end

        // Horizontal timing over the rest of line 0
        hs_first = -1; hs_last = -1; von_fall = -1; wrapped = 1'b0;
        y_before = -1; y_after = -1;
        prev_x = int'(a_if.pixel_x); prev_y = int'(a_if.pixel_y); prev_von = a_if.video_on;
        for (int n = 0; n < 4000 && !wrapped; n++) begin
            step();
            if (!a_if.hsync) begin
                if (hs_first < 0) hs_first = int'(a_if.pixel_x);
                hs_last = int'(a_if.pixel_x);
            end
            if (prev_von && !a_if.video_on && von_fall < 0) von_fall = int'(a_if.pixel_x);
            if (a_if.pixel_x == 0 && prev_x == 799) begin
                wrapped  = 1'b1;
                y_before = prev_y;
                y_after  = int'(a_if.pixel_y);
            end
            prev_x = int'(a_if.pixel_x); prev_y = int'(a_if.pixel_y); prev_von = a_if.video_on;
        end
        check("a_hsync_first", hs_first, 656);
        check("a_hsync_last", hs_last, 751);
        check("a_von_fall_x", von_fall, 640);
        check("a_hwrap_seen", 32'(wrapped), 1);
        check("a_y_before_wrap", y_before, 0);
        check("a_y_after_wrap", y_after, 1);

        // Vertical timing up to the first frame_start
        vs_min = 1000; vs_max = -1; vs_clocks = 0; seen = 1'b0;
        for (int n = 0; n < 25000 && !seen; n++) begin
            step();
            if (!a_if.vsync) begin
                vs_clocks++;
                if (int'(a_if.pixel_y) < vs_min) vs_min = int'(a_if.pixel_y);
                if (int'(a_if.pixel_y) > vs_max) vs_max = int'(a_if.pixel_y);
            end
            if (a_if.frame_start) seen = 1'b1;
        end
        check("a_fs_seen", 32'(seen), 1);
        check("a_vsync_min_line", vs_min, 5);
        check("a_vsync_max_line", vs_max, 5);
        check("a_vsync_clocks", vs_clocks, 3200);
        check("a_fs_x", a_if.pixel_x, 0);
        check("a_fs_y", a_if.pixel_y, 0);
        step();
        check("a_fs_one_clock", a_if.frame_start, 0);
        check("a_fs_next_x", a_if.pixel_x, 0);

        // Instance b: constant tick, first frame black despite new controls
        rst_b = 1'b0;
        step();
        check("b_tick_e1", b_if.pixel_tick, 1);
        check("b_x_e1", b_if.pixel_x, 0);
        check("b_von_e1", b_if.video_on, 1);
        check("b_rgb_e1", rgb_b(), 0);
        b_if.mode = 2'd0;
        b_if.sw   = 3'b101;
        for (int e = 2; e <= 5; e++) begin
            step();
            check("b_tick_const", b_if.pixel_tick, 1);
        end
        check("b_first_frame_black", rgb_b(), 0);

        // Frame 2: solid magenta-style 101
        wait_fs_b("b_fs1");
        fs1 = b_ticks;
        check("b_solid_00", rgb_b(), 32'h0F0F);
        wait_b(10, 0, "b_p10_0");
        check("b_solid_10", rgb_b(), 32'h0F0F);
        check("b_hsync_idle", b_if.hsync, 0);
        wait_b(700, 0, "b_p700_0");
        check("b_blank_rgb", rgb_b(), 0);
        check("b_blank_von", b_if.video_on, 0);
        check("b_hsync_act", b_if.hsync, 1);
        wait_b(0, 2, "b_p0_2");
        b_if.mode = 2'd1;
        wait_b(80, 2, "b_p80_2");
        check("b_midframe_solid", rgb_b(), 32'h0F0F);
        wait_b(0, 4, "b_p0_4");
        check("b_vblank_rgb", rgb_b(), 0);
        check("b_vsync_idle", b_if.vsync, 0);
        wait_b(0, 5, "b_p0_5");
        check("b_vsync_act", b_if.vsync, 1);

        // Frame 3: colour bars
        wait_fs_b("b_fs2");
        fs2 = b_ticks;
        check("b_frame_ticks", fs2 - fs1, 5600);
        check("b_bars_0", rgb_b(), 32'h0FFF);
        wait_b(79, 0, "b_p79_0");
        check("b_bars_79", rgb_b(), 32'h0FFF);
        wait_b(80, 0, "b_p80_0");
        check("b_bars_80", rgb_b(), 32'h0FF0);
        wait_b(320, 0, "b_p320_0");
        check("b_bars_320", rgb_b(), 32'h00FF);
        wait_b(639, 0, "b_p639_0");
        check("b_bars_639", rgb_b(), 0);
        wait_b(700, 0, "b_p700_0b");
        b_if.mode = 2'd3;

        // Frame 4: moving bar, fc = 3 after three wraps
        wait_fs_b("b_fs3");
        check("b_move_0", rgb_b(), 0);
        wait_b(2, 0, "b_p2_0");
        check("b_move_2", rgb_b(), 0);
        wait_b(3, 0, "b_p3_0");
        check("b_move_3", rgb_b(), 32'h0F0F);
        wait_b(18, 0, "b_p18_0");
        check("b_move_18", rgb_b(), 32'h0F0F);
        wait_b(19, 0, "b_p19_0");
        check("b_move_19", rgb_b(), 0);
        wait_b(3, 1, "b_p3_1");
        check("b_move_3_l1", rgb_b(), 32'h0F0F);
        wait_b(700, 1, "b_p700_1");
        b_if.mode = 2'd2;

        // Frame 5: checkerboard, sw change mid-frame ignored
        wait_fs_b("b_fs4");
        check("b_chk_0", rgb_b(), 32'h0F0F);
        wait_b(31, 0, "b_p31_0");
        check("b_chk_31", rgb_b(), 32'h0F0F);
        wait_b(32, 0, "b_p32_0");
        check("b_chk_32", rgb_b(), 32'h00F0);
        wait_b(40, 0, "b_p40_0");
        b_if.sw = 3'b011;
        wait_b(64, 0, "b_p64_0");
        check("b_chk_64", rgb_b(), 32'h0F0F);
        wait_b(96, 0, "b_p96_0");
        check("b_chk_96", rgb_b(), 32'h00F0);

        // Asynchronous reset between clock edges
        wait_b(300, 1, "b_p300_1");
        #2;
        rst_b = 1'b1;
        #1;
        check("b_arst_x", b_if.pixel_x, 0);
        check("b_arst_y", b_if.pixel_y, 0);
        check("b_arst_von", b_if.video_on, 0);
        check("b_arst_rgb", rgb_b(), 0);
        check("b_arst_hsync", b_if.hsync, 0);
        check("b_arst_vsync", b_if.vsync, 0);
        check("b_arst_tick", b_if.pixel_tick, 0);
        check("b_arst_fs", b_if.frame_start, 0);
        repeat (2) step();
        rst_b = 1'b0;
        step();
        check("b_rel_x", b_if.pixel_x, 0);
        check("b_rel_y", b_if.pixel_y, 0);
        check("b_rel_tick", b_if.pixel_tick, 1);
        check("b_rel_von", b_if.video_on, 1);
        check("b_rel_rgb", rgb_b(), 0);
        for (int e = 2; e <= 4; e++) begin
            step();
            check("b_rel_tick_const", b_if.pixel_tick, 1);
        end
        check("b_rel_x_e4", b_if.pixel_x, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
